// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its prefetch queue.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of fetch_entry_t, combinational head, synchronous flush.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW:0]     r_count;
  logic            w_pop;
  logic            w_push;

  assign empty  = (r_count == '0);
  assign full   = (r_count == (PW+1)'(DEPTH));
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH for free.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // NOTE: storage is not reset; the count alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit with prefetch queue, redirect handling and fault halt.
// Optional fetch bounds check against MEM_SIZE is enabled by defining FETCH_BOUNDS_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          MEM_SIZE = 1024,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_addr
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_fault_addr;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_full;
  logic         w_empty;
  logic         w_fetch_bad;
  logic         w_redirect_bad;
  fetch_entry_t w_head;

`ifdef FETCH_BOUNDS_CHECK_EN
  // 33-bit sum so an address near 2^32 cannot wrap past the limit.
  function automatic logic out_of_bounds(input logic [31:0] addr);
    return ({1'b0, addr} + 33'd3) >= 33'(MEM_SIZE);
  endfunction

  assign w_fetch_bad    = out_of_bounds(r_fetch_pc);
  assign w_redirect_bad = (|redirect_addr[1:0]) || out_of_bounds(redirect_addr);
`else
  assign w_fetch_bad    = 1'b0;
  assign w_redirect_bad = |redirect_addr[1:0];
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= RUN;
    else       r_state <= w_next_state;
  end

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (redirect_valid)
      w_next_state = w_redirect_bad ? FAULT : RUN;
    else if (r_state == RUN && w_fetch_bad)
      w_next_state = FAULT;
  end

  // A redirect outranks everything, including a full queue and a same-cycle dequeue.
  always_comb begin
    w_flush = redirect_valid || (r_state == RUN && w_fetch_bad);
    w_pop   = out_valid && out_ready && !redirect_valid;
    w_push  = (r_state == RUN) && !redirect_valid && !w_fetch_bad && (!w_full || w_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc   <= RESET_PC;
      r_fault_addr <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc   <= redirect_addr;
      r_fault_addr <= w_redirect_bad ? redirect_addr : '0;
    end else begin
      if (w_push) r_fetch_pc <= r_fetch_pc + 32'(WORD_BYTES);
      if (r_state == RUN && w_fetch_bad) r_fault_addr <= r_fetch_pc;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   ('{pc: r_fetch_pc, instr: imem_instruction}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Head fields read as zero while the queue is empty.
  assign imem_address = r_fetch_pc;
  assign out_valid    = !w_empty;
  assign out_instr    = out_valid ? w_head.instr : '0;
  assign out_pc       = out_valid ? w_head.pc    : '0;
  assign fault        = (r_state == FAULT);
  assign fault_addr   = r_fault_addr;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational hashed instruction memory.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_instruction = mem_word(imem_address);

  instr_fetch #(.DEPTH(4), .MEM_SIZE(1024), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_addr    (redirect_addr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .fault            (fault),
    .fault_addr       (fault_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] addr);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr  = 32'h42;
    out_ready      = 1'b1;
    step();
    step();
    check("rst_valid",     {31'b0, out_valid}, 32'h0);
    check("rst_fault",     {31'b0, fault},     32'h0);
    check("rst_fault_addr", fault_addr,        32'h0);
    check("rst_out_pc",    out_pc,             32'h0);
    check("rst_out_instr", out_instr,          32'h0);
    check("rst_imem_addr", imem_address,       32'h0);

    // Streaming from reset with the consumer always ready.
    reset          = 1'b0;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stream_valid", {31'b0, out_valid}, 32'h1);
      check("stream_pc",    out_pc,             32'(4 * i));
      check("stream_instr", out_instr,          mem_word(32'(4 * i)));
    end

    // Stall: queue fills with 0x0..0xC and fetch stops at 0x10.
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("stall_fetch_pc", imem_address,       32'h10);
    check("stall_head_pc",  out_pc,             32'h0);
    check("stall_valid",    {31'b0, out_valid}, 32'h1);

    // Drain in order with no bubble; full queue refills as it drains.
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check("drain_valid", {31'b0, out_valid}, 32'h1);
      check("drain_pc",    out_pc,             32'(4 * i));
    end
    check("drain_full_fetch_pc", imem_address, 32'h24);

    // Redirect while full and consumer ready.
    redirect(32'h40);
    check("redir_flush_valid", {31'b0, out_valid}, 32'h0);
    check("redir_fetch_pc",    imem_address,       32'h40);
    step();
    check("redir_valid", {31'b0, out_valid}, 32'h1);
    check("redir_pc",    out_pc,             32'h40);
    check("redir_instr", out_instr,          mem_word(32'h40));

    // Misaligned redirect halts; aligned redirect recovers.
    redirect(32'h42);
    check("mis_fault",      {31'b0, fault},     32'h1);
    check("mis_fault_addr", fault_addr,         32'h42);
    check("mis_valid",      {31'b0, out_valid}, 32'h0);
    step();
    step();
    check("mis_hold_fault", {31'b0, fault},     32'h1);
    check("mis_hold_valid", {31'b0, out_valid}, 32'h0);
    redirect(32'h8);
    check("recover_fault", {31'b0, fault},     32'h0);
    check("recover_valid", {31'b0, out_valid}, 32'h0);
    step();
    check("recover_pc", out_pc, 32'h8);

    // Approach the end of the 1 KiB instruction memory.
    redirect(32'h3F8);
    step();
    check("edge_pc0", out_pc, 32'h3F8);
    step();
    check("edge_pc1", out_pc, 32'h3FC);
    step();
`ifdef FETCH_BOUNDS_CHECK_EN
    check("bound_fault",      {31'b0, fault},     32'h1);
    check("bound_fault_addr", fault_addr,         32'h400);
    check("bound_valid",      {31'b0, out_valid}, 32'h0);
    redirect(32'h400);
    check("bound_redir_fault",      {31'b0, fault}, 32'h1);
    check("bound_redir_fault_addr", fault_addr,     32'h400);
`else
    check("nobound_pc",    out_pc,         32'h400);
    check("nobound_fault", {31'b0, fault}, 32'h0);
    // fetch_pc wraps modulo 2^32.
    redirect(32'hFFFF_FFF8);
    step();
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    step();
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", out_pc, 32'h0);
`endif

    // Reset clears a pending fault.
    redirect(32'h41);
    check("pre_rst_fault", {31'b0, fault}, 32'h1);
    reset = 1'b1;
    step();
    check("rst_clr_fault",      {31'b0, fault}, 32'h0);
    check("rst_clr_fault_addr", fault_addr,     32'h0);
    check("rst_clr_fetch_pc",   imem_address,   32'h0);
    reset = 1'b0;
    step();
    check("rst_restart_pc", out_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DEPTH, default 4: prefetch queue entries; power of two, at least 2.
REQ-002 SHALL have parameter MEM_SIZE, default 1024: instruction memory bytes; power of two.
REQ-003 SHALL have parameter RESET_PC, default 32'h0: first fetch address; word-aligned.
REQ-004 SHALL have port clk, input, 1: single clock; all state on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port imem_address, output, 32: byte address driven to instructmem.
REQ-007 SHALL have port imem_instruction, input, 32: combinational read data for imem_address.
REQ-008 SHALL have port redirect_valid, input, 1: branch or jump redirect request.
REQ-009 SHALL have port redirect_addr, input, 32: redirect target byte address.
REQ-010 SHALL have port out_valid, output, 1: queue head holds a valid instruction.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the head this cycle.
REQ-012 SHALL have port out_instr, output, 32: head instruction.
REQ-013 SHALL have port out_pc, output, 32: head instruction address.
REQ-014 SHALL have port fault, output, 1: fetch halted on a bad address.
REQ-015 SHALL have port fault_addr, output, 32: offending address, valid while fault is high.

Function
REQ-016 SHALL keep a fetch_pc register and drive imem_address = fetch_pc combinationally.
REQ-017 SHALL implement a two-state FSM: RUN and FAULT.
REQ-018 In RUN with no redirect, SHALL enqueue {fetch_pc, imem_instruction} and advance fetch_pc by 4 when the queue is not full, or is full and a dequeue occurs the same cycle.
REQ-019 SHALL perform a dequeue when out_valid && out_ready; simultaneous enqueue and dequeue SHALL leave the occupancy unchanged.
REQ-020 SHALL compute out_valid as queue not empty, and drive out_instr and out_pc from the head entry with no added latency.
REQ-021 SHALL wrap queue pointers modulo DEPTH; fetch_pc SHALL wrap modulo 2^32 (0xFFFFFFFC + 4 = 0).
REQ-022 On redirect_valid, SHALL flush all entries, ignore any same-cycle dequeue or enqueue, and load fetch_pc = redirect_addr; out_valid SHALL be low in the following cycle.
REQ-023 SHALL treat redirect_addr[1:0] != 0 as a fault: go to FAULT, fault_addr = redirect_addr, queue flushed.
REQ-024 In FAULT, SHALL perform no enqueue; existing entries are already flushed.
REQ-025 SHALL leave FAULT only on reset or on a redirect with a valid address; RUN resumes at that address.
REQ-026 SHALL give a redirect in the same cycle as a full queue priority over all other activity.

Reset
REQ-027 While reset is high: fetch_pc = RESET_PC, queue empty, state RUN, out_valid = 0, fault = 0, fault_addr = 0, out_instr = 0, out_pc = 0.
REQ-028 Reset SHALL override redirect_valid and any pending fault.
REQ-029 The first rising edge with reset low SHALL enqueue the word at RESET_PC; out_valid SHALL be high after that edge.

Configuration
REQ-030 Macro FETCH_BOUNDS_CHECK_EN defined: a fetch with fetch_pc + 3 >= MEM_SIZE SHALL not enqueue, SHALL enter FAULT with fault_addr = fetch_pc, and a redirect to such an address SHALL also fault.
REQ-031 Macro FETCH_BOUNDS_CHECK_EN undefined: no bounds check, and only misaligned redirects fault.

Structure
REQ-032 Package fetch_pkg SHALL hold fetch_entry_t {pc, instr}, fetch_state_e {RUN, FAULT}, and the constant WORD_BYTES = 4.
REQ-033 The queue SHALL be a sub-module fetch_fifo (DEPTH entries of fetch_entry_t, with full, empty, push, pop and flush).

Verification
REQ-034 Reset released with out_ready = 1 -> out_pc sequence 0x0, 0x4, 0x8, one per cycle, with out_instr equal to mem[0], mem[1], mem[2].
REQ-035 out_ready = 0 for 10 cycles with DEPTH = 4 -> queue holds pcs 0x0 to 0xC, fetch_pc = 0x10 and stalled; out_ready = 1 -> pcs drain in order with no gap.
REQ-036 redirect_valid with redirect_addr = 0x40 while the queue is full and out_ready = 1 -> next cycle out_valid = 0; the cycle after, out_pc = 0x40.
REQ-037 redirect_addr = 0x42 -> fault = 1, fault_addr = 0x42, out_valid stays 0; a later redirect to 0x8 -> fault = 0, out_pc = 0x8.
REQ-038 With FETCH_BOUNDS_CHECK_EN and MEM_SIZE = 1024, redirect to 0x3F8 -> pcs 0x3F8 and 0x3FC delivered, then fault = 1 with fault_addr = 0x400; without the macro, fetch continues to 0x400.
